// File: rtl/rpn_calc_pkg.sv
// Shared opcodes, error codes and FSM states
// for the RPN calculator engine.
package rpn_calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_EXP = 3'd4;
  localparam logic [2:0] OP_EQ  = 3'd5;
  localparam logic [2:0] OP_MOD = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_UNDER   = 3'd1;
  localparam logic [2:0] ERR_OVER    = 3'd2;
  localparam logic [2:0] ERR_DIVZ    = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER,
    OUT
  } state_t;

endpackage

// File: rtl/rpn_seq_alu.sv
// Iterative restoring divider / modulo and square-and-multiply
// exponent unit (exponent built only with RPN_CALC_EXP_EN).
import rpn_calc_pkg::*;

module rpn_seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  // x: remainder / accumulator, y: dividend->quotient / exponent,
  // d: divisor / base
  logic [WIDTH-1:0] x, y, d;
  logic [WIDTH-1:0] x_in, y_in, d_in;
  logic [WIDTH-1:0] x_nx, y_nx;
  logic [WIDTH:0]   sh;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
`ifdef RPN_CALC_EXP_EN
  logic [2:0]       op_in;
`endif

  // The start cycle already performs the first step, so
  // WIDTH steps finish in WIDTH clock edges.
  always_comb begin
    x_in = x;
    y_in = y;
    d_in = d;
    if (start) begin
      x_in = '0;
      y_in = a;
      d_in = b;
`ifdef RPN_CALC_EXP_EN
      if (op == OP_EXP) begin
        x_in = WIDTH'(1);
        y_in = b;
        d_in = a;
      end
`endif
    end
    sh   = {x_in, y_in[WIDTH-1]};
    x_nx = sh[WIDTH-1:0];
    y_nx = {y_in[WIDTH-2:0], 1'b0};
    if (sh >= {1'b0, d_in}) begin
      x_nx    = WIDTH'(sh - {1'b0, d_in});
      y_nx[0] = 1'b1;
    end
`ifdef RPN_CALC_EXP_EN
    op_in = start ? op : op_q;
    if (op_in == OP_EXP) begin
      x_nx = x_in * x_in;
      if (y_in[WIDTH-1])
        x_nx = x_nx * d_in;
      y_nx = {y_in[WIDTH-2:0], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      d    <= '0;
      op_q <= OP_ADD;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        x    <= x_nx;
        y    <= y_nx;
        d    <= d_in;
        op_q <= op;
        cnt  <= CW'(WIDTH - 1);
        busy <= 1'b1;
      end else if (busy) begin
        x   <= x_nx;
        y   <= y_nx;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign result = (op_q == OP_DIV) ? y : x;

endmodule

// File: rtl/rpn_calc_engine.sv
// RPN calculator engine: operand stack, control FSM, error reporting.
// Define RPN_CALC_EXP_EN to build the iterative exponent operator.
import rpn_calc_pkg::*;

module rpn_calc_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 20,
  parameter int LVLW  = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_is_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [2:0]       err_code,
  output logic [LVLW-1:0]  level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] stk [DEPTH];
  logic [2:0]       op;
  logic [AW-1:0]    p_idx, t_idx, n_idx;
  logic [WIDTH-1:0] top, nxt, res, alu_res;
  logic             accept, push, wr_res, clr;
  logic             set_err, set_eq;
  logic [2:0]       err_nx;
  logic             illegal, is_div, is_iter;
  logic             alu_start, alu_busy, alu_done;

  assign accept = in_valid & in_ready;
  assign p_idx  = AW'(level);
  assign t_idx  = AW'(level - LVLW'(1));
  assign n_idx  = AW'(level - LVLW'(2));
  assign top    = stk[t_idx];
  assign nxt    = stk[n_idx];
  assign is_div = (op == OP_DIV) || (op == OP_MOD);

`ifdef RPN_CALC_EXP_EN
  assign illegal = 1'b0;
  assign is_iter = is_div || (op == OP_EXP);
`else
  assign illegal = (op == OP_EXP);
  assign is_iter = is_div;
`endif

  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    wr_res    = 1'b0;
    clr       = 1'b0;
    set_err   = 1'b0;
    set_eq    = 1'b0;
    err_nx    = ERR_NONE;
    alu_start = 1'b0;
    res       = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (in_is_op) begin
            state_nx = EXEC;
          end else if (level == LVLW'(DEPTH)) begin
            set_err = 1'b1;
            err_nx  = ERR_OVER;
          end else begin
            push = 1'b1;
          end
        end
      end
      EXEC: begin
        state_nx = IDLE;
        priority case (1'b1)
          illegal: begin
            set_err = 1'b1;
            err_nx  = ERR_ILLEGAL;
          end
          op == OP_CLR: clr = 1'b1;
          op == OP_EQ: begin
            if (level == '0) begin
              set_err = 1'b1;
              err_nx  = ERR_UNDER;
            end else begin
              set_eq = 1'b1;
            end
          end
          level < LVLW'(2): begin
            set_err = 1'b1;
            err_nx  = ERR_UNDER;
          end
          is_div && (top == '0): begin
            set_err = 1'b1;
            err_nx  = ERR_DIVZ;
          end
          is_iter: begin
            alu_start = !alu_busy;
            state_nx  = ITER;
          end
          default: begin
            wr_res = 1'b1;
            case (op)
              OP_SUB:  res = nxt - top;
              OP_MUL:  res = nxt * top;
              default: res = nxt + top;
            endcase
          end
        endcase
      end
      ITER: begin
        if (alu_done) begin
          wr_res   = 1'b1;
          res      = alu_res;
          state_nx = IDLE;
        end
      end
      OUT: begin
        if (out_ready)
          state_nx = IDLE;
      end
    endcase
    if (set_err || set_eq)
      state_nx = OUT;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      err_code  <= ERR_NONE;
      level     <= '0;
      op        <= OP_ADD;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == IDLE);
      if (accept && in_is_op)
        op <= in_data[2:0];
      if (push)
        level <= level + LVLW'(1);
      if (wr_res)
        level <= level - LVLW'(1);
      if (clr || set_err || set_eq)
        level <= '0;
      if (set_err) begin
        out_valid <= 1'b1;
        out_err   <= 1'b1;
        err_code  <= err_nx;
        out_data  <= '0;
      end
      if (set_eq) begin
        out_valid <= 1'b1;
        out_err   <= 1'b0;
        err_code  <= ERR_NONE;
        out_data  <= top;
      end
      if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
        out_err   <= 1'b0;
        err_code  <= ERR_NONE;
      end
    end
  end

  // Stack storage needs no reset: occupancy is tracked by level.
  always_ff @(posedge CLK) begin
    if (push)
      stk[p_idx] <= in_data;
    if (wr_res)
      stk[n_idx] <= res;
  end

  rpn_seq_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .clk   (CLK),
    .rst_n (RST_N),
    .start (alu_start),
    .op    (op),
    .a     (nxt),
    .b     (top),
    .busy  (alu_busy),
    .done  (alu_done),
    .result(alu_res)
  );

endmodule

// File: tb/tb_rpn_calc_engine.sv
// Self-checking bench for rpn_calc_engine (WIDTH=32, DEPTH=4):
// vector table, hand sequences and a random run against a queue model.
module tb_rpn_calc_engine;
  import rpn_calc_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_is_op = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic [2:0]    err_code;
  logic [LW-1:0] level;

  rpn_calc_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_is_op (in_is_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .err_code (err_code),
    .level    (level)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  logic [31:0] ms [$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  code;
    logic [31:0] res;
  } vec_t;
  vec_t vt [$];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: in_ready timeout got %b expected 1", nm, in_ready);
    end
  endtask

  task automatic send(input bit is_op, input logic [31:0] d);
    wait_ready("send");
    in_valid = 1'b1;
    in_is_op = is_op;
    in_data  = d;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_is_op = 1'b0;
  endtask

  task automatic get_result(input string nm, input logic e,
                            input logic [2:0] c, input logic [31:0] v);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: out_valid timeout got %b expected 1", nm, out_valid);
      return;
    end
    check({nm, " err"}, out_err, e);
    check({nm, " code"}, err_code, c);
    check({nm, " data"}, out_data, v);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check({nm, " drop"}, out_valid, 0);
  endtask

  // Reference model: stack as a queue, operators from their definitions.
  task automatic model(input bit is_op, input logic [31:0] d,
                       output bit has_out, output logic [2:0] code,
                       output logic [31:0] val);
    logic [31:0] l, r, acc, base, e;
    has_out = 0;
    code    = 0;
    val     = 0;
    if (!is_op) begin
      if (ms.size() == D) begin
        has_out = 1; code = 2; ms.delete();
      end else begin
        ms.push_back(d);
      end
      return;
    end
    if (d[2:0] == 3'd7) begin
      ms.delete();
      return;
    end
`ifndef RPN_CALC_EXP_EN
    if (d[2:0] == 3'd4) begin
      has_out = 1; code = 4; ms.delete();
      return;
    end
`endif
    if (d[2:0] == 3'd5) begin
      has_out = 1;
      if (ms.size() == 0) code = 1;
      else val = ms[$];
      ms.delete();
      return;
    end
    if (ms.size() < 2) begin
      has_out = 1; code = 1; ms.delete();
      return;
    end
    r = ms.pop_back();
    l = ms.pop_back();
    if ((d[2:0] == 3'd3 || d[2:0] == 3'd6) && r == 0) begin
      has_out = 1; code = 3; ms.delete();
      return;
    end
    case (d[2:0])
      3'd0: ms.push_back(l + r);
      3'd1: ms.push_back(l - r);
      3'd2: ms.push_back(l * r);
      3'd3: ms.push_back(l / r);
      3'd6: ms.push_back(l % r);
      default: begin
        acc = 1; base = l; e = r;
        while (e != 0) begin
          if (e[0]) acc = acc * base;
          base = base * base;
          e = e >> 1;
        end
        ms.push_back(acc);
      end
    endcase
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0;
    bit isop, ho;
    logic [2:0] mc;
    logic [31:0] mv, d;
    bit stable;

    vt.push_back('{32'd3, 32'd4, OP_ADD, 3'd0, 32'd7});
    vt.push_back('{32'd10, 32'd3, OP_SUB, 3'd0, 32'd7});
    vt.push_back('{32'd3, 32'd10, OP_SUB, 3'd0, 32'hFFFF_FFF9});
    vt.push_back('{32'd6, 32'd7, OP_MUL, 3'd0, 32'd42});
    vt.push_back('{32'h1_0000, 32'h1_0000, OP_MUL, 3'd0, 32'd0});
    vt.push_back('{32'd17, 32'd5, OP_DIV, 3'd0, 32'd3});
    vt.push_back('{32'd17, 32'd5, OP_MOD, 3'd0, 32'd2});
    vt.push_back('{32'd5, 32'd9, OP_DIV, 3'd0, 32'd0});
    vt.push_back('{32'hFFFF_FFFF, 32'd1, OP_DIV, 3'd0, 32'hFFFF_FFFF});
    vt.push_back('{32'hFFFF_FFFF, 32'h10, OP_MOD, 3'd0, 32'hF});
    vt.push_back('{32'd7, 32'd0, OP_DIV, 3'd3, 32'd0});
    vt.push_back('{32'd7, 32'd0, OP_MOD, 3'd3, 32'd0});
`ifdef RPN_CALC_EXP_EN
    vt.push_back('{32'd2, 32'd10, OP_EXP, 3'd0, 32'd1024});
    vt.push_back('{32'd2, 32'd32, OP_EXP, 3'd0, 32'd0});
    vt.push_back('{32'd0, 32'd0, OP_EXP, 3'd0, 32'd1});
    vt.push_back('{32'd3, 32'd5, OP_EXP, 3'd0, 32'd243});
`else
    vt.push_back('{32'd2, 32'd10, OP_EXP, 3'd4, 32'd0});
`endif

    // reset values
    repeat (3) @(posedge CLK);
    #1;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_err", out_err, 0);
    check("rst err_code", err_code, 0);
    check("rst level", level, 0);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    check("rst release in_ready", in_ready, 1);

    // 3 4 + 5 * =
    send(0, 3); send(0, 4); send(1, OP_ADD);
    send(0, 5); send(1, OP_MUL); send(1, OP_EQ);
    get_result("chain", 0, 0, 35);
    check("chain level", level, 0);

    // divide by zero then empty EQ
    send(0, 7); send(0, 0); send(1, OP_DIV);
    get_result("div0", 1, 3, 0);
    check("div0 level", level, 0);
    send(1, OP_EQ);
    get_result("eq empty", 1, 1, 0);

    // modulo iteration length: EXEC + WIDTH ITER cycles
    send(0, 17); send(0, 5);
    send(1, {29'h1234567, OP_MOD});
    n = 0;
    while (!in_ready && n < 100) begin
      n++;
      @(posedge CLK); #1;
    end
    check("mod busy cycles", n, 33);
    check("mod level", level, 1);
    send(1, OP_EQ);
    get_result("mod eq", 0, 0, 2);

    // table vectors
    for (int i = 0; i < vt.size(); i++) begin
      send(0, vt[i].a); send(0, vt[i].b); send(1, vt[i].op);
      if (vt[i].code != 0) begin
        get_result($sformatf("vec%0d", i), 1, vt[i].code, 0);
      end else begin
        send(1, OP_EQ);
        get_result($sformatf("vec%0d", i), 0, 0, vt[i].res);
      end
      check($sformatf("vec%0d level", i), level, 0);
    end

    // back-to-back pushes, overflow, held output
    t0 = cyc;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    check("push throughput", cyc - t0, 4);
    check("full level", level, 4);
    send(0, 5);
    stable = 1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid !== 1 || out_err !== 1 || err_code !== 3'd2 ||
          out_data !== 0 || in_ready !== 0)
        stable = 0;
      @(posedge CLK); #1;
    end
    check("out held stable", stable, 1);
    get_result("overflow", 1, 2, 0);
    check("overflow level", level, 0);

    // underflow on binary op with one operand
    send(0, 1); send(1, OP_ADD);
    get_result("underflow", 1, 1, 0);

    // CLR produces no output
    send(0, 8); send(0, 9); send(1, OP_CLR);
    wait_ready("clr");
    check("clr level", level, 0);
    check("clr no out", out_valid, 0);

    // reset during DIV iteration
    send(0, 100); send(0, 7); send(1, OP_DIV);
    repeat (6) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("mid rst in_ready", in_ready, 0);
    check("mid rst level", level, 0);
    check("mid rst out_valid", out_valid, 0);
    check("mid rst out_err", out_err, 0);
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    send(0, 9); send(1, OP_EQ);
    get_result("after rst", 0, 0, 9);

    // random tokens against the model
    ms.delete();
    for (int i = 0; i < 300; i++) begin
      isop = ($urandom_range(0, 9) < 4);
      if (isop) begin
        d = $urandom();
      end else begin
        case ($urandom_range(0, 3))
          0: d = 0;
          1: d = $urandom_range(1, 40);
          default: d = $urandom();
        endcase
      end
      model(isop, d, ho, mc, mv);
      send(isop, d);
      if (ho)
        get_result("rnd", mc != 0, mc, mv);
      wait_ready("rnd");
      check("rnd level", level, 64'(ms.size()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
